cordic_arbiter: RTL and testbench

- Shares one pipelined first-quadrant CORDIC core among NUM_REQ requesters, each supplying full-circle angles.
- Round-robin arbitration; at most one issue per cycle.
- Folds each angle into quadrant I for the core and tags it with requester ID and quadrant in an in-flight FIFO.
- Un-folds core results into signed cos/sin and routes them back to the originating requester.

---
 rtl/cordic_arbiter.sv | 157 +++++++++++++++
 tb/tb_cordic_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter.sv
// cordic_arbiter
//   Shares one pipelined first-quadrant CORDIC core among NUM_REQ requesters.
//   Each requester supplies a full-circle angle {q, a}. The arbiter picks one
//   requester per cycle round-robin, sends the quadrant-I offset a to the core,
//   and remembers {id, q} in an in-flight tag FIFO. When the core returns a
//   result (in issue order), the head tag is popped. The magnitudes are then
//   rotated back into quadrant q as signed cos/sin and sent to the requester.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   req_valid/angle   per-requester request; angle = {q[1:0], a[BIT_WIDTH-1:0]}
//   req_ready         one-hot grant (handshake = valid & ready)
//   core_start/angle  registered issue to the core
//   core_x/y/done     core result magnitudes and strobe, in issue order
//   rsp_valid/id/x/y  one-cycle registered result, signed BIT_WIDTH+1 bits
//   busy              tags in flight or an issue pending
//   err               sticky: core_done arrived with nothing in flight
module cordic_arbiter #(
   parameter int BIT_WIDTH  = 16,
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = 2,
   parameter int FIFO_DEPTH = 18
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_REQ-1:0]                   req_valid,
   input  logic [NUM_REQ-1:0][BIT_WIDTH+1:0]    req_angle,
   output logic [NUM_REQ-1:0]                   req_ready,
   output logic                                 core_start,
   output logic [BIT_WIDTH-1:0]                 core_angle,
   input  logic [BIT_WIDTH-1:0]                 core_x,
   input  logic [BIT_WIDTH-1:0]                 core_y,
   input  logic                                 core_done,
   output logic [NUM_REQ-1:0]                   rsp_valid,
   output logic [ID_W-1:0]                      rsp_id,
   output logic [BIT_WIDTH:0]                   rsp_x,
   output logic [BIT_WIDTH:0]                   rsp_y,
   output logic                                 busy,
   output logic                                 err
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [1:0]      q;
   } tag_t;

   logic [ID_W-1:0]  last_grant, grant_id;
   logic             grant_any, can_grant, handshake;
   logic [CNT_W:0]   occupancy;
   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   tag_t             mem [FIFO_DEPTH];
   tag_t             issue_tag, head;
   logic             push, pop;
   logic [BIT_WIDTH:0] c_ext, s_ext;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!grant_any && req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
            grant_any = 1'b1;
            grant_id  = ID_W'((int'(last_grant) + k) % NUM_REQ);
         end
      end
   end

   // The tag of an accepted request lands in the FIFO one cycle later, together
   // with core_start. The pending issue therefore counts toward occupancy.
   // Otherwise a grant could overrun the FIFO.
   always_comb begin
      occupancy = {1'b0, count} + (CNT_W + 1)'(core_start);
      can_grant = reset && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
      handshake = can_grant & grant_any;
      req_ready = '0;
      if (handshake) req_ready[grant_id] = 1'b1;
   end

   assign push  = core_start;
   assign pop   = core_done && (count != '0);
   assign head  = mem[rd_ptr];
   assign c_ext = {1'b0, core_x};
   assign s_ext = {1'b0, core_y};
   assign busy  = (count != '0) | core_start;

   // Issue stage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         core_start <= 1'b0;
         core_angle <= '0;
         issue_tag  <= '0;
         last_grant <= ID_W'(NUM_REQ - 1);   // requester 0 searched first
      end else begin
         core_start <= handshake;
         if (handshake) begin
            core_angle <= req_angle[grant_id][BIT_WIDTH-1:0];
            issue_tag  <= '{id: grant_id, q: req_angle[grant_id][BIT_WIDTH+1:BIT_WIDTH]};
            last_grant <= grant_id;
         end
      end
   end

   // Tag storage needs no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= issue_tag;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Return stage: unfold quadrant-I magnitudes back to quadrant q.
   // Operands are zero-extended to BIT_WIDTH+1 bits, so negation cannot overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid <= '0;
         rsp_id    <= '0;
         rsp_x     <= '0;
         rsp_y     <= '0;
         err       <= 1'b0;
      end else begin
         err <= err | (core_done & (count == '0));
         for (int i = 0; i < NUM_REQ; i++)
            rsp_valid[i] <= pop && (head.id == ID_W'(i));
         if (pop) begin
            rsp_id <= head.id;
            case (head.q)
               2'd0: begin rsp_x <= c_ext;  rsp_y <= s_ext;  end
               2'd1: begin rsp_x <= -s_ext; rsp_y <= c_ext;  end
               2'd2: begin rsp_x <= -c_ext; rsp_y <= -s_ext; end
               default: begin rsp_x <= s_ext; rsp_y <= -c_ext; end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Testbench for cordic_arbiter. It uses a behavioural core model with fixed
// latency LAT and a stall control. Directed scenarios each check their own
// results inline.
module tb_cordic_arbiter;
   localparam int BW = 16, NR = 4, IDW = 2, FD = 18, LAT = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [NR-1:0]          req_valid = '0;
   logic [NR-1:0][BW+1:0]  req_angle = '0;
   logic [NR-1:0]          req_ready;
   logic                   core_start;
   logic [BW-1:0]          core_angle;
   logic [BW-1:0]          core_x = '0, core_y = '0;
   logic                   core_done = 1'b0;
   logic [NR-1:0]          rsp_valid;
   logic [IDW-1:0]         rsp_id;
   logic [BW:0]            rsp_x, rsp_y;
   logic                   busy, err;

   int checks = 0, errors = 0;

   cordic_arbiter #(.BIT_WIDTH(BW), .NUM_REQ(NR), .ID_W(IDW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_angle(req_angle),
      .req_ready(req_ready), .core_start(core_start), .core_angle(core_angle),
      .core_x(core_x), .core_y(core_y), .core_done(core_done),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y),
      .busy(busy), .err(err));

   // ---------------- core model ----------------
   typedef struct { logic [BW-1:0] a; int t; } job_t;
   job_t mq[$];
   int   cyc = 0;
   bit   stall = 0, fixed_mode = 0, inject = 0;

   function automatic logic [BW-1:0] fx(input logic [BW-1:0] a, input bit fixed);
      return fixed ? 16'hFFFF : a + 16'h1111;
   endfunction
   function automatic logic [BW-1:0] fy(input logic [BW-1:0] a, input bit fixed);
      return fixed ? 16'h0000 : a ^ 16'hF00F;
   endfunction

   always @(posedge clk) begin
      #1;
      cyc++;
      if (core_start === 1'b1) mq.push_back('{core_angle, cyc});
      core_done = 1'b0;
      if (inject) begin
         core_done = 1'b1; core_x = 16'h1234; core_y = 16'h5678;
      end else if (!stall && mq.size() != 0 && mq[0].t + LAT <= cyc) begin
         core_done = 1'b1;
         core_x = fx(mq[0].a, fixed_mode);
         core_y = fy(mq[0].a, fixed_mode);
         void'(mq.pop_front());
      end
   end

   // ---------------- monitors ----------------
   typedef struct { logic [IDW-1:0] id; logic [1:0] q; logic [BW-1:0] a; bit fixed; } exp_t;
   typedef struct { logic [NR-1:0] v; logic [IDW-1:0] id; logic [BW:0] x, y; } rsp_t;
   exp_t explog[$];
   rsp_t rsplog[$];
   int   glog[$];

   always @(negedge clk) begin
      if (reset) begin
         for (int i = 0; i < NR; i++)
            if (req_valid[i] && req_ready[i]) begin
               glog.push_back(i);
               explog.push_back('{IDW'(i), req_angle[i][BW+1:BW], req_angle[i][BW-1:0], fixed_mode});
            end
         if (rsp_valid != '0) rsplog.push_back('{rsp_valid, rsp_id, rsp_x, rsp_y});
      end
   end

   // Spec sign mapping on zero-extended core magnitudes.
   function automatic logic [2*(BW+1)-1:0] expect_xy(input exp_t e);
      int c, s, x, y;
      c = int'(fx(e.a, e.fixed));
      s = int'(fy(e.a, e.fixed));
      case (e.q)
         2'd0: begin x = c;  y = s;  end
         2'd1: begin x = -s; y = c;  end
         2'd2: begin x = -c; y = -s; end
         default: begin x = s; y = -c; end
      endcase
      return {(BW+1)'(x), (BW+1)'(y)};
   endfunction

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic clear_logs();
      rsplog.delete(); explog.delete(); glog.delete();
   endtask

   task automatic wait_rsp(input int n, input int budget, output bit ok);
      int k = 0;
      while (rsplog.size() < n && k < budget) begin tick(); k++; end
      ok = (rsplog.size() >= n);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      req_valid = 4'hF;
      tick(); tick();
      checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
      checks++; if (core_start !== 1'b0 || core_angle !== '0) begin errors++; $display("FAIL reset_core: got start=%b angle=%h want 0/0", core_start, core_angle); end
      checks++; if (rsp_valid !== '0 || rsp_id !== '0 || rsp_x !== '0 || rsp_y !== '0) begin errors++; $display("FAIL reset_rsp: got v=%b id=%0d x=%h y=%h want all 0", rsp_valid, rsp_id, rsp_x, rsp_y); end
      checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy=%b err=%b want 0/0", busy, err); end
      req_valid = '0;
      reset = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int n = 0;
      clear_logs();
      req_angle[2] = {2'd0, 16'h8000};
      req_valid = 4'b0100;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", req_ready); end
      tick();
      req_valid = '0;
      checks++; if (core_start !== 1'b1 || core_angle !== 16'h8000) begin errors++; $display("FAIL single_issue: got start=%b angle=%h want 1/8000", core_start, core_angle); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
      while (rsp_valid == '0 && n < 20) begin tick(); n++; end
      checks++; if (n != LAT + 1) begin errors++; $display("FAIL single_latency: got %0d cycles after handshake edge want %0d", n, LAT + 1); end
      checks++; if (rsp_valid !== 4'b0100 || rsp_id !== 2'd2) begin errors++; $display("FAIL single_route: got v=%b id=%0d want 0100/2", rsp_valid, rsp_id); end
      checks++; if (rsp_x !== 17'h09111 || rsp_y !== 17'h0700F) begin errors++; $display("FAIL single_data: got x=%h y=%h want 09111/0700f", rsp_x, rsp_y); end
      tick();
      checks++; if (rsp_valid !== '0 || busy !== 1'b0) begin errors++; $display("FAIL single_after: got v=%b busy=%b want 0/0", rsp_valid, busy); end
   endtask

   task automatic test_round_robin();
      bit ok;
      logic [BW-1:0] a;
      logic [BW:0] ex, ey;
      int want;
      clear_logs();
      for (int i = 0; i < NR; i++) req_angle[i] = {2'd1, 16'(16'h1000 * (i + 1))};
      req_valid = 4'hF;
      repeat (12) tick();
      req_valid = '0;
      wait_rsp(12, 40, ok);
      checks++; if (!ok || glog.size() != 12) begin errors++; $display("FAIL rr_count: got %0d grants %0d rsps want 12/12", glog.size(), rsplog.size()); end
      if (ok && glog.size() == 12) begin
         // last grant was requester 2, so the rotation begins at 3
         for (int k = 0; k < 12; k++) begin
            want = (k + 3) % NR;
            a  = 16'(16'h1000 * (want + 1));
            ex = -{1'b0, fy(a, 1'b0)};
            ey = {1'b0, fx(a, 1'b0)};
            checks++;
            if (glog[k] != want || rsplog[k].id !== IDW'(want) || rsplog[k].v !== (4'b0001 << want)
                || rsplog[k].x !== ex || rsplog[k].y !== ey) begin
               errors++;
               $display("FAIL rr_item%0d: got grant=%0d id=%0d v=%b x=%h y=%h want grant=%0d x=%h y=%h",
                        k, glog[k], rsplog[k].id, rsplog[k].v, rsplog[k].x, rsplog[k].y, want, ex, ey);
            end
         end
      end
   endtask

   task automatic test_quadrant();
      bit ok;
      logic [BW:0] xs [4];
      logic [BW:0] ys [4];
      xs = '{17'h0FFFF, 17'h00000, 17'h10001, 17'h00000};
      ys = '{17'h00000, 17'h0FFFF, 17'h00000, 17'h10001};
      clear_logs();
      fixed_mode = 1;
      req_valid = 4'b0001;
      for (int q = 0; q < 4; q++) begin
         req_angle[0] = {2'(q), 16'h0000};
         tick();
         if (q == 0) begin
            checks++; if (core_start !== 1'b1 || core_angle !== 16'h0000) begin errors++; $display("FAIL quad_zero_angle: got start=%b angle=%h want 1/0000", core_start, core_angle); end
         end
      end
      req_valid = '0;
      wait_rsp(4, 30, ok);
      checks++; if (!ok) begin errors++; $display("FAIL quad_count: got %0d rsps want 4", rsplog.size()); end
      if (ok)
         for (int q = 0; q < 4; q++) begin
            checks++;
            if (rsplog[q].id !== 2'd0 || rsplog[q].x !== xs[q] || rsplog[q].y !== ys[q]) begin
               errors++;
               $display("FAIL quad_q%0d: got id=%0d x=%h y=%h want 0 x=%h y=%h", q, rsplog[q].id, rsplog[q].x, rsplog[q].y, xs[q], ys[q]);
            end
         end
      fixed_mode = 0;
   endtask

   task automatic test_full();
      bit ok, seen_pp;
      int k;
      logic [2*(BW+1)-1:0] xy;
      clear_logs();
      stall = 1;
      for (int i = 0; i < NR; i++) req_angle[i] = {2'd2, 16'(16'hA000 + i * 16'h0101)};
      req_valid = 4'hF;
      repeat (25) tick();
      checks++; if (glog.size() != FD) begin errors++; $display("FAIL full_accepted: got %0d want %0d", glog.size(), FD); end
      repeat (5) begin
         checks++; if (req_ready !== 4'h0 || busy !== 1'b1) begin errors++; $display("FAIL full_hold: got ready=%b busy=%b want 0000/1", req_ready, busy); end
         tick();
      end
      stall = 0;
      seen_pp = 0;
      k = 0;
      while (glog.size() < FD + 4 && k < 60) begin
         tick();
         if (core_start && core_done) seen_pp = 1;
         k++;
      end
      req_valid = '0;
      checks++; if (glog.size() != FD + 4 || !seen_pp) begin errors++; $display("FAIL full_refill: got grants=%0d push_with_pop=%0d want %0d/1", glog.size(), seen_pp, FD + 4); end
      wait_rsp(FD + 4, 100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL full_drain: got %0d rsps want %0d", rsplog.size(), FD + 4); end
      if (ok && glog.size() == FD + 4)
         for (int j = 0; j < FD + 4; j++) begin
            xy = expect_xy(explog[j]);
            checks++;
            // previous grant was requester 0, so issue order is 1,2,3,0,...
            if (glog[j] != (j + 1) % NR || rsplog[j].id !== explog[j].id
                || rsplog[j].x !== xy[2*BW+1:BW+1] || rsplog[j].y !== xy[BW:0]) begin
               errors++;
               $display("FAIL full_item%0d: got grant=%0d id=%0d x=%h y=%h want grant=%0d id=%0d x=%h y=%h",
                        j, glog[j], rsplog[j].id, rsplog[j].x, rsplog[j].y, (j + 1) % NR, explog[j].id,
                        xy[2*BW+1:BW+1], xy[BW:0]);
            end
         end
   endtask

   task automatic test_err();
      clear_logs();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_initial: got %b want 0", err); end
      inject = 1;
      tick();
      inject = 0;
      tick();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err); end
      repeat (3) tick();
      checks++; if (err !== 1'b1 || rsplog.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL err_sticky: got err=%b rsps=%0d busy=%b want 1/0/0", err, rsplog.size(), busy); end
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      int k = 0;
      reset = 1'b0;
      tick(); tick();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err_clear: got %b want 0", err); end
      reset = 1'b1;
      tick();
      clear_logs();
      for (int i = 0; i < NR; i++) req_angle[i] = {2'd3, 16'(16'h2000 + i)};
      req_valid = 4'hF;
      repeat (5) tick();
      reset = 1'b0;
      #1;
      checks++; if (req_ready !== '0 || core_start !== 1'b0 || core_angle !== '0) begin errors++; $display("FAIL mid_reset_issue: got ready=%b start=%b angle=%h want 0", req_ready, core_start, core_angle); end
      checks++; if (rsp_valid !== '0 || rsp_id !== '0 || rsp_x !== '0 || rsp_y !== '0 || busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_reset_out: got v=%b id=%0d x=%h y=%h busy=%b err=%b want 0", rsp_valid, rsp_id, rsp_x, rsp_y, busy, err); end
      req_valid = '0;
      tick(); tick();
      reset = 1'b1;
      rsplog.delete();
      while (mq.size() != 0 && k < 20) begin tick(); k++; end
      tick();
      checks++; if (err !== 1'b1 || rsplog.size() != 0) begin errors++; $display("FAIL mid_stale_done: got err=%b rsps=%0d want 1/0", err, rsplog.size()); end
      clear_logs();
      req_valid = 4'hF;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_rr_restart: got %b want 0001", req_ready); end
      tick();
      req_valid = '0;
      wait_rsp(1, 20, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL mid_next_rsp: got no response want one");
      end else if (rsplog[0].v !== 4'b0001 || rsplog[0].id !== 2'd0 || rsplog[0].x !== 17'h0D00F || rsplog[0].y !== 17'h1CEEF) begin
         errors++; $display("FAIL mid_next_rsp: got v=%b id=%0d x=%h y=%h want 0001/0/0d00f/1ceef", rsplog[0].v, rsplog[0].id, rsplog[0].x, rsplog[0].y);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_quadrant();
      test_full();
      test_err();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
